// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin scheduler draining NCH FWFT FIFOs into one framed output stream.
// Define FIFO_ARB_TIMEOUT_EN to compile in per-channel timers and single-word stale grants.
module fifo_burst_arbiter #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned NBITS   = 64,
  parameter int unsigned BURST   = 16,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*NBITS-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_almost_empty,
  output logic [NCH-1:0]       in_read,
  output logic [NBITS-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [CW-1:0]        o_chan,
  output logic                 o_first,
  output logic                 o_last,
  output logic                 busy
);

  localparam int unsigned LW = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    g, g_d, p, p_d;
  logic             is_full, is_full_d;
  logic [LW-1:0]    count, count_d, last_idx;
  logic [NBITS-1:0] o_data_d;
  logic             o_valid_d, o_first_d, o_last_d;
  logic [CW-1:0]    o_chan_d;
  logic [NCH-1:0]   full, stale, elig;
  logic             found, pop;
  logic [CW-1:0]    sel, idx;
  logic [NBITS-1:0] word [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_word
    assign word[c] = in_data[c*NBITS +: NBITS];
  end

  assign full = en & in_valid & ~in_almost_empty;
  assign elig = full | stale;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer [NCH];

  // Age of residual data; a stale grant leaves it saturated so the channel drains one word per round.
  for (genvar c = 0; c < NCH; c++) begin : g_timer
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        timer[c] <= '0;
      end else if (!in_valid[c] || !in_almost_empty[c]) begin
        timer[c] <= '0;
      end else if (state == IDLE && found && sel == CW'(c) && full[c]) begin
        timer[c] <= '0;
      end else if (!(state == GRANT && g == CW'(c)) && timer[c] != TW'(TIMEOUT)) begin
        timer[c] <= timer[c] + TW'(1);
      end
    end
    assign stale[c] = en[c] & in_valid[c] & (timer[c] == TW'(TIMEOUT));
  end
`else
  logic unused_timeout;
  assign stale          = '0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = CW'((32'(p) + i) % NCH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign last_idx = is_full ? LW'(BURST - 1) : '0;
  assign pop      = (state == GRANT) && in_valid[g] && (!o_valid || o_ready);

  always_comb begin
    state_d   = state;
    g_d       = g;
    p_d       = p;
    is_full_d = is_full;
    count_d   = count;
    o_data_d  = o_data;
    o_valid_d = o_valid;
    o_chan_d  = o_chan;
    o_first_d = o_first;
    o_last_d  = o_last;
    in_read   = '0;

    case (state)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          g_d       = sel;
          is_full_d = full[sel];
          count_d   = '0;
          p_d       = (sel == CW'(NCH - 1)) ? '0 : sel + CW'(1);
        end
      end
      GRANT: begin
        if (pop) begin
          in_read[g] = 1'b1;
          count_d    = count + LW'(1);
          if (count == last_idx) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register: load on pop, otherwise drain once accepted.
    if (pop) begin
      o_data_d  = word[g];
      o_valid_d = 1'b1;
      o_chan_d  = g;
      o_first_d = (count == '0);
      o_last_d  = (count == last_idx);
    end else if (o_valid && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      g       <= '0;
      p       <= '0;
      is_full <= 1'b0;
      count   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_chan  <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      state   <= state_d;
      g       <= g_d;
      p       <= p_d;
      is_full <= is_full_d;
      count   <= count_d;
      o_data  <= o_data_d;
      o_valid <= o_valid_d;
      o_chan  <= o_chan_d;
      o_first <= o_first_d;
      o_last  <= o_last_d;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: FIFO queues feed the DUT, a transaction-level arbiter model is
// compared every cycle, and directed scenarios pin burst framing, latency, fairness and timeouts.
module tb_fifo_burst_arbiter;
  localparam int unsigned NCH     = 4;
  localparam int unsigned NBITS   = 16;
  localparam int unsigned BURST   = 16;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned CW      = 2;
`ifdef FIFO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NCH-1:0]       en = '1;
  logic [NCH*NBITS-1:0] in_data = '0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH-1:0]       in_almost_empty = '1;
  logic [NCH-1:0]       in_read;
  logic [NBITS-1:0]     o_data;
  logic                 o_valid;
  logic                 o_ready = 1'b1;
  logic [CW-1:0]        o_chan;
  logic                 o_first, o_last, busy;

  fifo_burst_arbiter #(.NCH(NCH), .NBITS(NBITS), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_almost_empty(in_almost_empty), .in_read(in_read), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_chan(o_chan), .o_first(o_first), .o_last(o_last), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef logic [NBITS-1:0] word_q_t [$];
  typedef struct { int cyc; int ch; int data; bit f; bit l; } ent_t;

  word_q_t        fifo [NCH];
  ent_t           olog [$];
  logic [NCH-1:0] en_next = '1;
  int             rdy_mode = 0;
  int             n_tests = 0, n_fail = 0, cyc = 0;
  int             first_vld_cyc = -1, first_rd_cyc = -1, first_ov_cyc = -1;

  // Arbiter model: grant as (channel, words left), one-entry output slot, per-channel wait ages.
  int             m_p, m_g, m_left, m_sent;
  bit             m_act, m_ov, m_of, m_ol;
  int             m_od, m_oc;
  int             m_timer [NCH];
  logic [NCH-1:0] exp_rd;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_g = 0; m_left = 0; m_sent = 0; m_act = 0;
    m_ov = 0; m_of = 0; m_ol = 0; m_od = 0; m_oc = 0;
    for (int c = 0; c < NCH; c++) m_timer[c] = 0;
  endtask

  task automatic model_step();
    bit was_act;
    int was_g;
    was_act = m_act;
    was_g   = m_g;
    if (exp_rd != '0) begin
      m_od = int'(fifo[m_g][0]); m_ov = 1; m_oc = m_g;
      m_of = (m_sent == 0); m_ol = (m_left == 1);
      m_sent++; m_left--;
      if (m_left == 0) m_act = 0;
    end else if (m_ov && o_ready) begin
      m_ov = 0;
    end
    if (!was_act) begin
      for (int i = 0; i < NCH; i++) begin
        int  c;
        bit  is_full, is_stale;
        c        = (m_p + i) % NCH;
        is_full  = en[c] && in_valid[c] && !in_almost_empty[c];
        is_stale = TO_EN && en[c] && in_valid[c] && (m_timer[c] == TIMEOUT);
        if (!m_act && (is_full || is_stale)) begin
          m_act = 1; m_g = c; m_sent = 0;
          m_left = is_full ? BURST : 1;
          m_p = (c + 1) % NCH;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (!in_valid[c] || !in_almost_empty[c]) m_timer[c] = 0;
      else if (!(was_act && was_g == c) && m_timer[c] < TIMEOUT) m_timer[c]++;
    end
  endtask

  // Drive FIFO heads at negedge, then compare and advance model and queues.
  always @(negedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      in_valid[c]        = (fifo[c].size() > 0);
      in_almost_empty[c] = (fifo[c].size() < 16);
      in_data[c*NBITS +: NBITS] = (fifo[c].size() > 0) ? fifo[c][0] : '0;
    end
    en = en_next;
    case (rdy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ~o_ready;
      default: o_ready = ($urandom_range(9, 0) < 7);
    endcase
    #1;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      exp_rd = '0;
      if (m_act && fifo[m_g].size() > 0 && (!m_ov || o_ready)) exp_rd[m_g] = 1'b1;
      chk("in_read", int'(in_read), int'(exp_rd));
      chk("busy", int'(busy), int'(m_act));
      chk("o_valid", int'(o_valid), int'(m_ov));
      if (m_ov) begin
        chk("o_data", int'(o_data), m_od);
        chk("o_chan", int'(o_chan), m_oc);
        chk("o_first", int'(o_first), int'(m_of));
        chk("o_last", int'(o_last), int'(m_ol));
      end
      if (o_valid && !o_ready) chk("rd_stall", int'(in_read), 0);
      if (first_vld_cyc < 0 && in_valid != '0) first_vld_cyc = cyc;
      if (first_rd_cyc < 0 && in_read != '0) first_rd_cyc = cyc;
      if (first_ov_cyc < 0 && o_valid) first_ov_cyc = cyc;
      if (o_valid && o_ready)
        olog.push_back('{cyc, int'(o_chan), int'(o_data), o_first, o_last});
      model_step();
      for (int c = 0; c < NCH; c++)
        if (in_read[c] && fifo[c].size() > 0) void'(fifo[c].pop_front());
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic do_reset(input int mode);
    @(negedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_in_read", int'(in_read), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_busy", int'(busy), 0);
    for (int c = 0; c < NCH; c++) fifo[c].delete();
    olog.delete();
    first_vld_cyc = -1; first_rd_cyc = -1; first_ov_cyc = -1;
    en_next  = '1;
    rdy_mode = mode;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load(input int c, input int n, input int base);
    for (int i = 0; i < n; i++) fifo[c].push_back(NBITS'(base + i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nb, n0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    chk("reset_o_data", int'(o_data), 0);
    chk("reset_o_chan", int'(o_chan), 0);
    chk("reset_o_first", int'(o_first), 0);
    chk("reset_o_last", int'(o_last), 0);
    chk("reset_o_valid", int'(o_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_read", int'(in_read), 0);
    @(negedge clock);
    reset = 1'b0;

    // Single full channel: two bursts, residue stays unless timeouts are compiled in.
    do_reset(0);
    @(posedge clock); load(1, 40, 'h100);
    run(200);
    chk("t1_words", olog.size(), TO_EN ? 40 : 32);
    chk("t1_left", fifo[1].size(), TO_EN ? 0 : 8);
    chk("t1_rd_lat", first_rd_cyc - first_vld_cyc, 1);
    chk("t1_ov_lat", first_ov_cyc - first_vld_cyc, 2);
    if (olog.size() >= 32) begin
      chk("t1_first0", int'(olog[0].f), 1);
      chk("t1_last15", int'(olog[15].l), 1);
      chk("t1_first16", int'(olog[16].f), 1);
      chk("t1_last31", int'(olog[31].l), 1);
      chk("t1_mid_flags", int'(olog[7].f | olog[7].l), 0);
      chk("t1_data0", olog[0].data, 'h100);
      chk("t1_data31", olog[31].data, 'h11f);
      chk("t1_chan", olog[20].ch, 1);
      chk("t1_span", olog[15].cyc - olog[0].cyc, 15);
      chk("t1_gap", olog[16].cyc - olog[15].cyc, 2);
    end

    // Round-robin fairness across four full channels.
    do_reset(0);
    @(posedge clock);
    for (int c = 0; c < NCH; c++) load(c, 40, c * 256);
    run(200);
    nb = 0;
    for (int i = 0; i < olog.size(); i++) begin
      if (olog[i].f && nb < 8) begin
        chk("rr_order", olog[i].ch, nb % 4);
        if (i > 0) chk("rr_gap", olog[i].cyc - olog[i-1].cyc, 2);
        nb++;
      end
    end
    chk("rr_bursts", int'(nb >= 8), 1);

    // Backpressure: o_ready alternates, sixteen words arrive intact and in order.
    do_reset(1);
    @(posedge clock); load(3, 16, 'h300);
    run(80);
    chk("bp_words", olog.size(), 16);
    for (int i = 0; i < olog.size() && i < 16; i++) chk("bp_data", olog[i].data, 'h300 + i);
    if (olog.size() >= 16) chk("bp_last", int'(olog[15].l), 1);

    // Residual data below the almost-empty threshold.
    do_reset(0);
    @(posedge clock); load(2, 3, 'h200);
    run(60);
    chk("to_words", olog.size(), TO_EN ? 3 : 0);
    chk("to_left", fifo[2].size(), TO_EN ? 0 : 3);
    chk("to_lat", (first_ov_cyc < 0) ? -1 : first_ov_cyc - first_vld_cyc, TO_EN ? 12 : -1);
    for (int i = 0; i < olog.size(); i++) begin
      chk("to_single", int'(olog[i].f & olog[i].l), 1);
      chk("to_chan", olog[i].ch, 2);
    end

    // Enable dropped mid-burst: that burst completes, channel 0 is then never granted.
    do_reset(0);
    @(posedge clock);
    for (int c = 0; c < NCH; c++) load(c, 48, c * 256);
    k = 0;
    while (olog.size() < 4 && k < 40) begin @(posedge clock); k++; end
    chk("en_wait", int'(olog.size() >= 4), 1);
    en_next[0] = 1'b0;
    run(300);
    n0 = 0;
    for (int i = 0; i < olog.size(); i++) if (olog[i].ch == 0) n0++;
    chk("en_ch0_words", n0, 16);

    // Reset mid-burst, then the pointer must start again at channel 0.
    do_reset(0);
    @(posedge clock); load(2, 32, 'h200); load(3, 32, 'h300);
    k = 0;
    while (olog.size() < 3 && k < 40) begin @(posedge clock); k++; end
    chk("rst_wait", int'(olog.size() >= 3), 1);
    do_reset(0);
    @(posedge clock); load(0, 20, 'h000); load(1, 20, 'h100); load(3, 20, 'h300);
    run(70);
    chk("ptr_words", int'(olog.size() >= 32), 1);
    if (olog.size() >= 32) begin
      chk("ptr_first_chan", olog[0].ch, 0);
      chk("ptr_second_chan", olog[16].ch, 1);
    end

    // Randomised traffic, enables and backpressure against the model.
    do_reset(2);
    for (int t = 0; t < 600; t++) begin
      @(posedge clock);
      if ($urandom_range(7, 0) == 0)
        load(int'($urandom_range(NCH - 1, 0)), int'($urandom_range(24, 1)), int'($urandom_range(65535, 0)));
      if ($urandom_range(63, 0) == 0)
        en_next[$urandom_range(NCH - 1, 0)] ^= 1'b1;
    end
    en_next = '1;
    run(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
